router_1x3: RTL and testbench
=============================

Name: router_1x3

Overview:
- Single-input, three-output packet router.
- Accepts byte-serial packets on data_in framed by pkt_valid and decodes a 2-bit destination from the header.
- Buffers each packet in one of three per-port FIFOs; downstream readers drain each FIFO with read_enb_n.
- Flags parity mismatches on `error` and applies back-pressure to the source via `busy`.

Parameters:
- WIDTH, 8, data byte width
- DEPTH, 16, words per output FIFO (power of 2)
- TIMEOUT, 30, clocks a FIFO may sit with vld_out high and no read before soft reset

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- read_enb_0 / read_enb_1 / read_enb_2  in  1 each  pop request for FIFO 0/1/2
- data_in  in  8  header, payload or parity byte
- pkt_valid  in  1  high for header and payload bytes; low on the parity byte
- data_out_0 / data_out_1 / data_out_2  out  8 each  popped byte
- vld_out_0 / vld_out_1 / vld_out_2  out  1 each  FIFO non-empty
- error  out  1  parity mismatch on the last packet
- busy  out  1  source must hold data_in and pkt_valid stable while high

Behaviour:
- Packet format:
  - Header = {len[7:2], addr[1:0]}; len is 1..63 payload bytes.
  - Header is followed by len payload bytes (pkt_valid=1), then one parity byte (pkt_valid=0).
  - Parity = XOR of header and all payload bytes.
- Reset: all FIFOs empty, pointers 0, data_out_n=0, vld_out_n=0, error=0, busy=0, FSM in DECODE_ADDRESS, parity accumulator 0. Reset mid-packet discards everything.
- FSM, sampled on each rising edge; "target" means the FIFO selected by the latched addr:
  - DECODE_ADDRESS, busy=0:
    - If pkt_valid and addr<3: latch header. Go to LOAD_FIRST_DATA if target empty, else WAIT_TILL_EMPTY.
    - If pkt_valid and addr==3: go to DROP.
    - Otherwise stay.
  - WAIT_TILL_EMPTY, busy=1: go to LOAD_FIRST_DATA when target is empty.
  - LOAD_FIRST_DATA, busy=1: write the latched header into target; parity accumulator = header; go to LOAD_DATA.
  - LOAD_DATA, busy = target full (combinational). When target not full, write data_in:
    - pkt_valid=1: accumulator ^= data_in; stay.
    - pkt_valid=0: byte is parity; write it too, register the received parity, go to CHECK_PARITY.
  - CHECK_PARITY, busy=1: error <= (accumulator != received parity); go to DECODE_ADDRESS. error holds until the next CHECK_PARITY or reset.
  - DROP, busy=0: discard bytes; return to DECODE_ADDRESS on the cycle pkt_valid=0 (parity swallowed); error unchanged.
- FIFO (per port):
  - Write only from the FSM, never when full.
  - read_enb_n & !empty pops: data_out_n updates on the next rising edge (1-cycle latency); otherwise data_out_n holds.
  - Simultaneous read and write, including when full, is legal: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - vld_out_n = !empty (combinational from count).
- Soft reset: per FIFO, count consecutive clocks with vld_out_n=1 and read_enb_n=0. When the count reaches TIMEOUT, flush that FIFO (pointers and count to 0). If the FSM is currently loading into it, return the FSM to DECODE_ADDRESS. Any read clears the counter.
- Outputs of unselected FIFOs are unaffected by traffic to other ports.

Decomposition:
- Package router_pkg:
  - state enum: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, CHECK_PARITY, DROP
  - WIDTH, DEPTH, TIMEOUT constants
  - ADDR_INVALID=2'b11
- Sub-module router_fifo: DEPTH x WIDTH FIFO with soft-reset flush and timeout counter, instantiated three times as fifo_0, fifo_1, fifo_2.
- FSM, header and parity logic live in the top.

Test Plan:
- Reset, then send header 8'h39 (len 14, addr 1), 14 random bytes and correct parity, with read_enb_1=0 -> vld_out_1=1 after the header write; FIFO holds 16 bytes, full after parity. Then read_enb_1=1 until vld_out_1=0 -> data_out_1 returns header, payload and parity in order; error=0; vld_out_0/2 stay 0.
- Packet len 20 to addr 1, reading started before the header -> busy pulses while FIFO 1 is full. All 22 bytes arrive in order, none lost or duplicated; error=0.
- Len 9 packet to addr 2 with parity bit 0 flipped -> error=1 one clock after the parity write. The next correct packet clears error to 0.
- Header addr=3 (8'h27, len 9) followed by 9 bytes and parity -> no FIFO writes, busy=0 throughout, vld_out all 0. A following valid packet to addr 0 routes correctly.
- Packet to addr 0 left unread -> after 30 clocks with vld_out_0=1, FIFO 0 flushes and vld_out_0=0. A second packet to addr 0 sent while the first is unread -> busy in WAIT_TILL_EMPTY until the flush, then loads.
- Assert resetn=0 mid-payload -> all vld_out=0, busy=0, error=0 immediately (asynchronous); a new packet after release routes correctly.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared constants, FSM state encodings and the parity helper
// for the 1x3 packet router.
//   WIDTH / DEPTH / TIMEOUT : default data width, FIFO depth, idle timeout
//   ADDR_INVALID            : header address that selects no port (dropped)
//   state_t + state consts  : legacy-style FSM encodings
//   parity_update()         : running XOR used for packet parity
package router_pkg;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t DECODE_ADDRESS  = 3'd0;
  localparam state_t WAIT_TILL_EMPTY = 3'd1;
  localparam state_t LOAD_FIRST_DATA = 3'd2;
  localparam state_t LOAD_DATA       = 3'd3;
  localparam state_t CHECK_PARITY    = 3'd4;
  localparam state_t DROP            = 3'd5;

  function automatic logic [WIDTH-1:0] parity_update(input logic [WIDTH-1:0] acc,
                                                     input logic [WIDTH-1:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: DEPTH x WIDTH output FIFO for one router port.
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   write_enb     : push write_data (ignored when full unless popping too)
//   read_enb      : pop request; data_out updates one clock after a pop
//   vld_out       : FIFO non-empty
//   full          : FIFO holds DEPTH words
//   soft_reset    : high on the clock that flushes the FIFO after it has sat
//                   TIMEOUT clocks non-empty with no read
module router_fifo
  import router_pkg::*;
#(
  parameter int WIDTH   = router_pkg::WIDTH,
  parameter int DEPTH   = router_pkg::DEPTH,
  parameter int TIMEOUT = router_pkg::TIMEOUT
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             write_enb,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             vld_out,
  output logic             full,
  output logic             soft_reset
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [TW-1:0]    idle_cnt_r;
  logic             pop_s;
  logic             push_s;
  logic             stall_s;

  // Status flags, push/pop qualification and the timeout flush strobe.
  always_comb begin
    vld_out    = (count_r != '0);
    full       = (count_r == (AW+1)'(DEPTH));
    pop_s      = read_enb && vld_out;
    stall_s    = vld_out && !read_enb;
    soft_reset = stall_s && (idle_cnt_r == TW'(TIMEOUT - 1));
    // A full FIFO still accepts a word when one leaves on the same clock;
    // a flush wins over any write arriving on that clock.
    push_s     = write_enb && (!full || pop_s) && !soft_reset;
  end

  // Storage array (no reset: contents are only meaningful below count_r).
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= write_data;
    end
  end

  // Pointers and occupancy; soft reset empties the FIFO in one clock.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (soft_reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Read data register: holds its value except on a pop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out <= '0;
    end else if (pop_s) begin
      data_out <= mem_r[rd_ptr_r];
    end
  end

  // Consecutive unread-while-valid clock counter; any read restarts it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_r <= '0;
    end else if (stall_s && !soft_reset) begin
      idle_cnt_r <= idle_cnt_r + TW'(1);
    end else begin
      idle_cnt_r <= '0;
    end
  end

endmodule

// File: rtl/router_1x3.sv
// router_1x3: one-input, three-output byte-serial packet router.
//   clock, resetn        : rising-edge clock, asynchronous active-low reset
//   data_in, pkt_valid   : header/payload (pkt_valid=1) then parity (pkt_valid=0)
//   read_enb_0..2        : pop requests for the three output FIFOs
//   data_out_0..2        : popped bytes (one clock after the pop)
//   vld_out_0..2         : output FIFO non-empty
//   error                : parity mismatch on the last checked packet
//   busy                 : source must hold data_in/pkt_valid while high
module router_1x3
  import router_pkg::*;
#(
  parameter int WIDTH   = router_pkg::WIDTH,
  parameter int DEPTH   = router_pkg::DEPTH,
  parameter int TIMEOUT = router_pkg::TIMEOUT
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             read_enb_0,
  input  logic             read_enb_1,
  input  logic             read_enb_2,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pkt_valid,
  output logic [WIDTH-1:0] data_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic [WIDTH-1:0] data_out_2,
  output logic             vld_out_0,
  output logic             vld_out_1,
  output logic             vld_out_2,
  output logic             error,
  output logic             busy
);

  state_t           state_r;
  logic [WIDTH-1:0] hdr_r;
  logic [WIDTH-1:0] parity_acc_r;
  logic [WIDTH-1:0] rx_parity_r;
  logic             error_r;

  logic [2:0]       write_enb_s;
  logic [WIDTH-1:0] write_data_s;
  logic [2:0]       full_s;
  logic [2:0]       vld_s;
  logic [2:0]       soft_reset_s;
  logic [1:0]       addr_s;
  logic             tgt_full_s;
  logic             tgt_empty_s;
  logic             tgt_soft_reset_s;
  logic             in_empty_s;
  logic             loading_s;

  function automatic logic port_bit(input logic [2:0] v, input logic [1:0] a);
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] port_onehot(input logic [1:0] a);
    case (a)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Target-port status, FIFO write steering and the busy handshake.
  always_comb begin
    addr_s           = hdr_r[1:0];
    tgt_full_s       = port_bit(full_s, addr_s);
    tgt_empty_s      = !port_bit(vld_s, addr_s);
    tgt_soft_reset_s = port_bit(soft_reset_s, addr_s);
    // Header is not latched yet in DECODE_ADDRESS, so look at the incoming one.
    in_empty_s       = !port_bit(vld_s, data_in[1:0]);
    loading_s        = (state_r == LOAD_FIRST_DATA) || (state_r == LOAD_DATA);
    write_enb_s      = 3'b000;
    write_data_s     = data_in;
    busy             = 1'b0;
    case (state_r)
      DECODE_ADDRESS:  busy = 1'b0;
      WAIT_TILL_EMPTY: busy = 1'b1;
      LOAD_FIRST_DATA: begin
        busy         = 1'b1;
        write_enb_s  = port_onehot(addr_s);
        write_data_s = hdr_r;
      end
      LOAD_DATA: begin
        busy = tgt_full_s;
        if (!tgt_full_s) begin
          write_enb_s = port_onehot(addr_s);
        end else begin
          write_enb_s = 3'b000;
        end
      end
      CHECK_PARITY:    busy = 1'b1;
      DROP:            busy = 1'b0;
      default:         busy = 1'b0;
    endcase
  end

  // Packet FSM with header latch, parity accumulation and error flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r      <= DECODE_ADDRESS;
      hdr_r        <= '0;
      parity_acc_r <= '0;
      rx_parity_r  <= '0;
      error_r      <= 1'b0;
    end else if (tgt_soft_reset_s && loading_s) begin
      // The target was flushed under us: abandon the rest of the packet.
      state_r <= DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (data_in[1:0] != ADDR_INVALID) begin
              hdr_r   <= data_in;
              state_r <= in_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end else begin
              state_r <= DROP;
            end
          end
        end
        WAIT_TILL_EMPTY: begin
          if (tgt_empty_s) begin
            state_r <= LOAD_FIRST_DATA;
          end
        end
        LOAD_FIRST_DATA: begin
          parity_acc_r <= hdr_r;
          state_r      <= LOAD_DATA;
        end
        LOAD_DATA: begin
          if (!tgt_full_s) begin
            if (pkt_valid) begin
              parity_acc_r <= parity_update(parity_acc_r, data_in);
            end else begin
              rx_parity_r <= data_in;
              state_r     <= CHECK_PARITY;
            end
          end
        end
        CHECK_PARITY: begin
          error_r <= (parity_acc_r != rx_parity_r);
          state_r <= DECODE_ADDRESS;
        end
        DROP: begin
          if (!pkt_valid) begin
            state_r <= DECODE_ADDRESS;
          end
        end
        default: state_r <= DECODE_ADDRESS;
      endcase
    end
  end

  assign error = error_r;

  router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) fifo_0 (
    .clock(clock), .resetn(resetn),
    .write_enb(write_enb_s[0]), .write_data(write_data_s), .read_enb(read_enb_0),
    .data_out(data_out_0), .vld_out(vld_s[0]), .full(full_s[0]),
    .soft_reset(soft_reset_s[0])
  );

  router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) fifo_1 (
    .clock(clock), .resetn(resetn),
    .write_enb(write_enb_s[1]), .write_data(write_data_s), .read_enb(read_enb_1),
    .data_out(data_out_1), .vld_out(vld_s[1]), .full(full_s[1]),
    .soft_reset(soft_reset_s[1])
  );

  router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) fifo_2 (
    .clock(clock), .resetn(resetn),
    .write_enb(write_enb_s[2]), .write_data(write_data_s), .read_enb(read_enb_2),
    .data_out(data_out_2), .vld_out(vld_s[2]), .full(full_s[2]),
    .soft_reset(soft_reset_s[2])
  );

  assign vld_out_0 = vld_s[0];
  assign vld_out_1 = vld_s[1];
  assign vld_out_2 = vld_s[2];

endmodule

// File: tb/tb_router_1x3.sv
// tb_router_1x3: scoreboard bench for router_1x3. Bytes are pushed to a
// per-port expected queue as they are driven and popped when the port's
// data_out presents a popped byte.
module tb_router_1x3;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       read_enb_0 = 1'b0;
  logic       read_enb_1 = 1'b0;
  logic       read_enb_2 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       error, busy;

  int         total = 0;
  int         bad = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         rd_mode [3] = '{0, 0, 0};   // 0 idle, 1 always, 2 every 8th clock
  int         cyc = 0;
  logic [2:0] pend = 3'b000;
  int         run0 = 0;
  int         flush_drop0 = 0;
  logic       flush_pend = 1'b0;
  logic [23:0] dout_all;
  logic [2:0]  vld_all;
  logic [2:0]  rd_all;

  assign dout_all = {data_out_2, data_out_1, data_out_0};
  assign vld_all  = {vld_out_2, vld_out_1, vld_out_0};
  assign rd_all   = {read_enb_2, read_enb_1, read_enb_0};

  router_1x3 dut (
    .clock(clock), .resetn(resetn),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .data_in(data_in), .pkt_valid(pkt_valid),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .error(error), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_size(input int p);
    case (p)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] exp_pop(input int p);
    case (p)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push_exp(input int p, input logic [7:0] b);
    case (p)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Reader pattern generator, driven just after each rising edge.
  always @(posedge clock) begin
    #1;
    cyc = cyc + 1;
    read_enb_0 = (rd_mode[0] == 1) || (rd_mode[0] == 2 && (cyc % 8) == 0);
    read_enb_1 = (rd_mode[1] == 1) || (rd_mode[1] == 2 && (cyc % 8) == 0);
    read_enb_2 = (rd_mode[2] == 1) || (rd_mode[2] == 2 && (cyc % 8) == 0);
  end

  // Output monitor: checks popped bytes and models the port-0 idle flush.
  always @(negedge clock) begin
    if (!resetn) begin
      pend       = 3'b000;
      run0       = 0;
      flush_pend = 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (pend[p]) begin
          check_val($sformatf("pop_has_expected_%0d", p), 32'(exp_size(p) != 0), 32'd1);
          if (exp_size(p) != 0)
            check_val($sformatf("data_out_%0d", p), 32'(dout_all[p*8 +: 8]), 32'(exp_pop(p)));
        end
      end
      if (flush_pend) begin
        check_val("flush_vld_out_0", 32'(vld_out_0), 32'd0);
        flush_pend = 1'b0;
      end
      pend = rd_all & vld_all;
      if (vld_out_0 && !read_enb_0) begin
        run0++;
        if (run0 == TIMEOUT) begin
          for (int k = 0; k < flush_drop0; k++)
            if (q0.size() != 0) q0.delete(0);
          flush_pend = 1'b1;
        end
      end else begin
        run0 = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic pv, input logic no_stall,
                           output int stalls);
    int n;
    n = 0;
    data_in   = b;
    pkt_valid = pv;
    @(negedge clock);
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) check_val("busy_timeout", 32'(n), 32'd0);
    if (no_stall) check_val("drop_no_stall", 32'(n), 32'd0);
    @(posedge clock);
    #1;
    stalls = n;
  endtask

  task automatic send_pkt(input int len, input logic [1:0] addr, input logic bad_par,
                          output int stalls);
    logic [7:0] hdr, par, b;
    int st;
    logic drop;
    drop   = (addr == 2'd3);
    hdr    = {len[5:0], addr};
    par    = hdr;
    stalls = 0;
    if (!drop) push_exp(int'(addr), hdr);
    send_byte(hdr, 1'b1, 1'b0, st);
    for (int i = 0; i < len; i++) begin
      b   = 8'($urandom_range(255, 0));
      par = par ^ b;
      if (!drop) push_exp(int'(addr), b);
      send_byte(b, 1'b1, drop, st);
      stalls += st;
    end
    if (bad_par) par = par ^ 8'h01;
    if (!drop) push_exp(int'(addr), par);
    send_byte(par, 1'b0, drop, st);
    stalls += st;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic wait_drain(input int p, input string tag);
    int n;
    n = 0;
    while ((vld_all[p] || exp_size(p) != 0) && n < 3000) begin
      @(negedge clock);
      #1;
      n++;
    end
    check_val({tag, "_drain_done"}, 32'(n < 3000), 32'd1);
    check_val({tag, "_sb_left"}, 32'(exp_size(p)), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [7:0] b;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_vld", 32'(vld_all), 32'd0);
    check_val("rst_dout", 32'(dout_all), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_error", 32'(error), 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // T1: fill FIFO 1 to exactly DEPTH with no reader, then drain it.
    send_pkt(14, 2'd1, 1'b0, st);
    check_val("t1_vld1", 32'(vld_out_1), 32'd1);
    check_val("t1_vld0", 32'(vld_out_0), 32'd0);
    check_val("t1_vld2", 32'(vld_out_2), 32'd0);
    @(posedge clock);
    #1;
    check_val("t1_error", 32'(error), 32'd0);
    rd_mode[1] = 1;
    wait_drain(1, "t1");
    check_val("t1_vld0_after", 32'(vld_out_0), 32'd0);
    check_val("t1_vld2_after", 32'(vld_out_2), 32'd0);

    // T2: slow reader on port 1 forces back-pressure through a full FIFO.
    rd_mode[1] = 2;
    repeat (3) @(posedge clock);
    #1;
    send_pkt(20, 2'd1, 1'b0, st);
    check_val("t2_busy_stalls", 32'(st > 0), 32'd1);
    wait_drain(1, "t2");
    check_val("t2_error", 32'(error), 32'd0);
    rd_mode[1] = 1;

    // T3: bad parity to port 2, dropped packet in between, then good packet.
    rd_mode[2] = 1;
    send_pkt(9, 2'd2, 1'b1, st);
    check_val("t3_error_latency", 32'(error), 32'd0);
    @(posedge clock);
    #1;
    check_val("t3_error_set", 32'(error), 32'd1);
    send_pkt(9, 2'd3, 1'b0, st);
    check_val("t3_drop_vld01", 32'({vld_out_1, vld_out_0}), 32'd0);
    check_val("t3_drop_error_held", 32'(error), 32'd1);
    wait_drain(2, "t3a");
    check_val("t3_drop_vld_all", 32'(vld_all), 32'd0);
    send_pkt(5, 2'd2, 1'b0, st);
    @(posedge clock);
    #1;
    check_val("t3_error_clear", 32'(error), 32'd0);
    wait_drain(2, "t3b");

    // T4: a valid packet to port 0 after the drop routes normally.
    rd_mode[0] = 1;
    send_pkt(4, 2'd0, 1'b0, st);
    wait_drain(0, "t4");

    // T5: unread packet on port 0 times out; a second one waits for the flush.
    rd_mode[0] = 0;
    repeat (2) @(posedge clock);
    #1;
    send_pkt(3, 2'd0, 1'b0, st);
    flush_drop0 = q0.size();
    send_pkt(3, 2'd0, 1'b0, st);
    check_val("t5_wait_busy", 32'(st >= 20), 32'd1);
    flush_drop0 = 0;
    rd_mode[0] = 1;
    wait_drain(0, "t5");

    // T6: asynchronous reset in the middle of a payload.
    send_pkt(6, 2'd2, 1'b1, st);
    @(posedge clock);
    #1;
    check_val("t6_error_pre", 32'(error), 32'd1);
    wait_drain(2, "t6a");
    rd_mode[1] = 0;
    send_byte(8'h29, 1'b1, 1'b0, st);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(255, 0));
      send_byte(b, 1'b1, 1'b0, st);
    end
    check_val("t6_vld1_pre", 32'(vld_out_1), 32'd1);
    resetn = 1'b0;
    #2;
    check_val("t6_rst_vld", 32'(vld_all), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_error", 32'(error), 32'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    rd_mode[1] = 1;
    @(posedge clock);
    #1;
    send_pkt(7, 2'd1, 1'b0, st);
    wait_drain(1, "t6b");
    check_val("t6_error_after", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
